// File: rtl/sprite_display.sv
// sprite_display: animated sprite renderer for a raster video pipeline.
// Hit-tests the current pixel against a fixed-size sprite box. It then
// issues a registered address to an external 1-cycle-latency image ROM and
// returns the pixel color two cycles after the x/y sample.
// A small FSM (IDLE/PLAY/DONE) steps through NUM_FRAMES animation frames
// stored back-to-back in the ROM, one step every TICKS_PER_FRAME frame_ticks.
// Optional feature: define SPRITE_TRANSPARENCY_EN to treat ROM pixels equal
// to TRANSPARENT_COLOR as misses (color-keyed transparency).
module sprite_display #(
  parameter int unsigned LEFT_EDGE         = 90,
  parameter int unsigned SPR_WIDTH         = 35,
  parameter int unsigned SPR_HEIGHT        = 35,
  parameter int unsigned BITS_PER_COLOR    = 12,
  parameter int unsigned NUM_FRAMES        = 4,
  parameter int unsigned TICKS_PER_FRAME   = 6,
  parameter int unsigned TRANSPARENT_COLOR = 12'h000,
  parameter int unsigned ADDR_W            = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
  input  logic [31:0]               sprite_top,
  input  logic                      frame_tick,
  input  logic                      anim_en,
  input  logic                      anim_oneshot,
  input  logic                      restart,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [BITS_PER_COLOR-1:0] rom_data,
  output logic                      inside_sprite,
  output logic [BITS_PER_COLOR-1:0] colorData,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx,
  output logic                      anim_done
);

  localparam int unsigned FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned CNT_W      = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int unsigned FRAME_SIZE = SPR_WIDTH * SPR_HEIGHT;
  localparam logic [CNT_W-1:0]   LAST_TICK  = CNT_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  // Elaboration-time sanity checks on the parameter set
  if (ADDR_W < $clog2(NUM_FRAMES * FRAME_SIZE)) begin : g_bad_addr_w
    $error("sprite_display: ADDR_W too small for NUM_FRAMES*SPR_WIDTH*SPR_HEIGHT");
  end
  if ((64'(TRANSPARENT_COLOR) >> BITS_PER_COLOR) != 64'd0) begin : g_bad_key
    $error("sprite_display: TRANSPARENT_COLOR wider than BITS_PER_COLOR");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  anim_state_t        state, state_next;
  logic [CNT_W-1:0]   counter, counter_next;
  logic [FRAME_W-1:0] frame_next;

  logic [31:0]        x_wide, y_wide;
  logic               pix_hit;
  logic [ADDR_W-1:0]  pix_addr;
  logic               hit_d1, hit_d2;

  // Hit test and ROM address for the current pixel, all at 32-bit unsigned
  always_comb begin
    x_wide   = 32'(x);
    y_wide   = 32'(y);
    pix_hit  = (x_wide >= LEFT_EDGE) && (x_wide < LEFT_EDGE + SPR_WIDTH) &&
               (y_wide >= sprite_top) && (y_wide < sprite_top + SPR_HEIGHT);
    pix_addr = ADDR_W'(32'(frame_idx) * FRAME_SIZE + (x_wide - LEFT_EDGE) +
                       SPR_WIDTH * (y_wide - sprite_top));
  end

  // Pixel pipeline: register ROM address and carry the hit flag two stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
    end else begin
      rom_addr <= pix_hit ? pix_addr : '0;
      hit_d1   <= pix_hit;
      hit_d2   <= hit_d1;
    end
  end

`ifdef SPRITE_TRANSPARENCY_EN
  assign inside_sprite = hit_d2 && (rom_data != BITS_PER_COLOR'(TRANSPARENT_COLOR));
`else
  assign inside_sprite = hit_d2;
`endif

  assign colorData = inside_sprite ? rom_data : '0;
  assign anim_done = (state == DONE);

  // Animation state, tick counter and frame index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      frame_idx <= '0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      frame_idx <= frame_next;
    end
  end

  // Next-state logic: disable and restart override normal playback
  always_comb begin
    state_next   = state;
    counter_next = counter;
    frame_next   = frame_idx;
    if (!anim_en) begin
      state_next   = IDLE;
      counter_next = '0;
      frame_next   = '0;
    end else if (restart) begin
      state_next   = PLAY;
      counter_next = '0;
      frame_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next   = PLAY;
          counter_next = '0;
          frame_next   = '0;
        end
        PLAY: begin
          if (frame_tick) begin
            if (counter == LAST_TICK) begin
              counter_next = '0;
              if (frame_idx == LAST_FRAME) begin
                if (anim_oneshot) begin
                  state_next = DONE;
                end else begin
                  frame_next = '0;
                end
              end else begin
                frame_next = frame_idx + FRAME_W'(1);
              end
            end else begin
              counter_next = counter + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next   = IDLE;
          counter_next = '0;
          frame_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_display.sv
// tb_sprite_display: directed, table-driven bench for sprite_display.
// A behavioural 1-cycle-latency ROM feeds rom_data. Address 0 holds the
// color key (12'h000), address 1 holds 12'hF80, and every other address
// holds addr[11:0] ^ 12'h5A5.
module tb_sprite_display;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [31:0] sprite_top = 32'd100;
  logic        frame_tick = 1'b0;
  logic        anim_en = 1'b0;
  logic        anim_oneshot = 1'b0;
  logic        restart = 1'b0;
  logic [12:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        inside_sprite;
  logic [11:0] colorData;
  logic [1:0]  frame_idx;
  logic        anim_done;

  int tests = 0;
  int fails = 0;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef struct {
    logic [9:0]  vx;
    logic [8:0]  vy;
    logic [12:0] exp_addr;
    logic        exp_inside;
    logic [11:0] exp_color;
  } vec_t;

  vec_t vecs[10];

  sprite_display dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .x             (x),
    .y             (y),
    .sprite_top    (sprite_top),
    .frame_tick    (frame_tick),
    .anim_en       (anim_en),
    .anim_oneshot  (anim_oneshot),
    .restart       (restart),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .inside_sprite (inside_sprite),
    .colorData     (colorData),
    .frame_idx     (frame_idx),
    .anim_done     (anim_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [12:0] a);
    if (a == 13'd0) return 12'h000;
    if (a == 13'd1) return 12'hF80;
    return a[11:0] ^ 12'h5A5;
  endfunction

  // Behavioural image ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] xv, input logic [8:0] yv);
    x = xv;
    y = yv;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tickFrame(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      stepCycle();
      frame_tick = 1'b0;
    end
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    stepCycle();
    restart = 1'b0;
  endtask

  initial begin
    int px[3];
    int py[3];
    int pa[3];
    int pin[3];
    int pc[3];

    // Single-pixel vectors, frame 0, sprite_top = 100
    vecs[0] = '{10'd91,   9'd100, 13'd1,    1'b1, 12'hF80};
    vecs[1] = '{10'd124,  9'd134, 13'd1224, 1'b1, 12'h16D};
    vecs[2] = '{10'd125,  9'd100, 13'd0,    1'b0, 12'h000};
    vecs[3] = '{10'd89,   9'd110, 13'd0,    1'b0, 12'h000};
    vecs[4] = '{10'd100,  9'd99,  13'd0,    1'b0, 12'h000};
    vecs[5] = '{10'd100,  9'd135, 13'd0,    1'b0, 12'h000};
    vecs[6] = '{10'd100,  9'd110, 13'd360,  1'b1, 12'h4CD};
    vecs[7] = '{10'd124,  9'd100, 13'd34,   1'b1, 12'h587};
    vecs[8] = '{10'd90,   9'd134, 13'd1190, 1'b1, 12'h103};
    vecs[9] = '{10'd1023, 9'd511, 13'd0,    1'b0, 12'h000};

    // Reset and check reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    checkOutput("reset_frame_idx", 32'(frame_idx), 32'd0);
    checkOutput("reset_anim_done", 32'(anim_done), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_inside", 32'(inside_sprite), 32'd0);
    checkOutput("reset_color", 32'(colorData), 32'd0);

    // Table-driven pixel checks, one vector at a time
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].vx, vecs[i].vy);
      stepCycle();
      checkOutput($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      stepCycle();
      checkOutput($sformatf("vec%0d_inside", i), 32'(inside_sprite), 32'(vecs[i].exp_inside));
      checkOutput($sformatf("vec%0d_color", i), 32'(colorData), 32'(vecs[i].exp_color));
    end

    // Back-to-back pixels: one per cycle, outputs two cycles after input
    px  = '{90, 124, 125};
    py  = '{100, 134, 100};
    pa  = '{0, 1224, 0};
    pin = '{KEY_EN ? 0 : 1, 1, 0};
    pc  = '{0, 12'h16D, 0};
    for (int c = 0; c < 4; c++) begin
      if (c < 3) applyStimulus(10'(px[c]), 9'(py[c]));
      stepCycle();
      if (c < 3) checkOutput($sformatf("pipe%0d_rom_addr", c), 32'(rom_addr), 32'(pa[c]));
      if (c >= 1) begin
        checkOutput($sformatf("pipe%0d_inside", c - 1), 32'(inside_sprite), 32'(pin[c - 1]));
        checkOutput($sformatf("pipe%0d_color", c - 1), 32'(colorData), 32'(pc[c - 1]));
      end
    end

    // Looping animation, 24 ticks; frame change reaches rom_addr one cycle later
    applyStimulus(10'd91, 9'd101);
    anim_en = 1'b1;
    anim_oneshot = 1'b0;
    stepCycle();
    for (int t = 1; t <= 24; t++) begin
      tickFrame(1);
      checkOutput($sformatf("loop_tick%0d_frame", t), 32'(frame_idx), 32'((t / 6) % 4));
      if (t == 12) begin
        checkOutput("loop_addr_old_frame", 32'(rom_addr), 32'd1261);
        stepCycle();
        checkOutput("loop_addr_frame2", 32'(rom_addr), 32'd2486);
      end
    end
    checkOutput("loop_anim_done", 32'(anim_done), 32'd0);

    // One-shot playback, then restart
    pulseRestart();
    checkOutput("os_start_frame", 32'(frame_idx), 32'd0);
    anim_oneshot = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tickFrame(1);
      checkOutput($sformatf("os_tick%0d_frame", t), 32'(frame_idx), (t >= 18) ? 32'd3 : 32'(t / 6));
      checkOutput($sformatf("os_tick%0d_done", t), 32'(anim_done), (t >= 24) ? 32'd1 : 32'd0);
    end
    pulseRestart();
    checkOutput("os_restart_frame", 32'(frame_idx), 32'd0);
    checkOutput("os_restart_done", 32'(anim_done), 32'd0);
    tickFrame(6);
    checkOutput("os_restart_play", 32'(frame_idx), 32'd1);
    anim_oneshot = 1'b0;

    // Restart wins over a simultaneous frame_tick at counter = 5
    pulseRestart();
    tickFrame(11);
    checkOutput("rt_pre_frame", 32'(frame_idx), 32'd1);
    restart = 1'b1;
    frame_tick = 1'b1;
    stepCycle();
    restart = 1'b0;
    frame_tick = 1'b0;
    checkOutput("rt_same_cycle_frame", 32'(frame_idx), 32'd0);
    tickFrame(5);
    checkOutput("rt_counter_cleared", 32'(frame_idx), 32'd0);
    tickFrame(1);
    checkOutput("rt_first_advance", 32'(frame_idx), 32'd1);
    tickFrame(6);
    checkOutput("en_pre_frame", 32'(frame_idx), 32'd2);
    anim_en = 1'b0;
    stepCycle();
    checkOutput("en_off_frame", 32'(frame_idx), 32'd0);
    anim_en = 1'b1;
    stepCycle();

    // Asynchronous reset mid-sprite at frame 3
    pulseRestart();
    tickFrame(18);
    checkOutput("rst_pre_frame", 32'(frame_idx), 32'd3);
    applyStimulus(10'd100, 9'd110);
    stepCycle();
    stepCycle();
    checkOutput("rst_pre_rom_addr", 32'(rom_addr), 32'd4035);
    checkOutput("rst_pre_inside", 32'(inside_sprite), 32'd1);
    checkOutput("rst_pre_color", 32'(colorData), 32'hA66);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_async_inside", 32'(inside_sprite), 32'd0);
    checkOutput("rst_async_color", 32'(colorData), 32'd0);
    checkOutput("rst_async_frame", 32'(frame_idx), 32'd0);
    checkOutput("rst_async_done", 32'(anim_done), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    stepCycle();
    checkOutput("rst_post1_rom_addr", 32'(rom_addr), 32'd360);
    checkOutput("rst_post1_inside", 32'(inside_sprite), 32'd0);
    stepCycle();
    checkOutput("rst_post2_inside", 32'(inside_sprite), 32'd1);
    checkOutput("rst_post2_color", 32'(colorData), 32'h4CD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
